// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage: issues req/ready fetches and holds one instruction for IF_ID.
// Optional macro PC_MISALIGN_TRAP_EN redirects misaligned branch targets to TRAP_VECTOR and raises a sticky misalignTrap.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branchFlag,
    input  logic [31:0] branchAddr,
    input  logic        imemReady,
    input  logic [31:0] imemData,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    output logic [31:0] instOut,
    output logic [31:0] pcOut,
    output logic        instValid,
    output logic        flushIFID,
    output logic        misalignTrap
);

`ifdef PC_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    typedef enum logic {
        S_FETCH = 1'b0,
        S_KILL  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic        trap_q, trap_d;

    logic        can_issue;
    logic        branch_take;
    logic        misaligned;
    logic [31:0] target;
    logic        req;
    logic        accept;

    always_comb begin
        can_issue   = !valid_q || !stall;
        branch_take = branchFlag && !stall;
        misaligned  = TRAP_EN && (branchAddr[1:0] != 2'b00);
        target      = misaligned ? TRAP_VECTOR : (branchAddr & ~32'h3);

        // In S_KILL the wrong-path request is already in flight and must stay up.
        if (rst) begin
            req = 1'b0;
        end else if (state_q == S_KILL) begin
            req = 1'b1;
        end else begin
            req = can_issue;
        end
        // Data returned without an open request is never consumed.
        accept = req && imemReady;
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        inst_d      = inst_q;
        pc_out_d    = pc_out_q;
        valid_d     = valid_q;
        trap_d      = trap_q;

        case (state_q)
            S_FETCH: begin
                if (branch_take) begin
                    valid_d = 1'b0;
                    if (accept || !req) begin
                        pc_d = target;
                    end else begin
                        pend_addr_d = target;
                        state_d     = S_KILL;
                    end
                end else if (accept) begin
                    inst_d   = imemData;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + 32'd4;
                end else if (!stall) begin
                    valid_d = 1'b0;
                end
            end
            S_KILL: begin
                if (branch_take) begin
                    valid_d = 1'b0;
                end
                // A branch arriving with the wrong-path response still wins.
                if (accept) begin
                    pc_d    = branch_take ? target : pend_addr_q;
                    state_d = S_FETCH;
                end else if (branch_take) begin
                    pend_addr_d = target;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (branch_take && misaligned) begin
            trap_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            pend_addr_q <= RESET_PC;
            inst_q      <= 32'h0;
            pc_out_q    <= 32'h0;
            valid_q     <= 1'b0;
            trap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            inst_q      <= inst_d;
            pc_out_q    <= pc_out_d;
            valid_q     <= valid_d;
            trap_q      <= trap_d;
        end
    end

    assign imemReq      = req;
    assign imemAddr     = pc_q;
    assign instOut      = inst_q;
    assign pcOut        = pc_out_q;
    assign instValid    = valid_q;
    assign flushIFID    = !rst && branch_take;
    assign misalignTrap = TRAP_EN ? trap_q : 1'b0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus randomized traffic against a fetch-stream model.
// Honours PC_MISALIGN_TRAP_EN the same way as the design.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branchFlag;
    logic [31:0] branchAddr;
    logic        imemReady;
    logic [31:0] imemData;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic [31:0] instOut;
    logic [31:0] pcOut;
    logic        instValid;
    logic        flushIFID;
    logic        misalignTrap;

    pc_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branchFlag   (branchFlag),
        .branchAddr   (branchAddr),
        .imemReady    (imemReady),
        .imemData     (imemData),
        .imemReq      (imemReq),
        .imemAddr     (imemAddr),
        .instOut      (instOut),
        .pcOut        (pcOut),
        .instValid    (instValid),
        .flushIFID    (flushIFID),
        .misalignTrap (misalignTrap)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    // Model: where the next fetch goes, whether the open request is wrong-path
    // (and where we go once it returns), and what IF_ID is being offered.
    logic [31:0] m_fetch;
    bit          m_wrong;
    logic [31:0] m_redirect;
    bit          m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    bit          m_trap;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    endtask

    task automatic model_reset();
        m_fetch    = 32'h0;
        m_wrong    = 1'b0;
        m_redirect = 32'h0;
        m_valid    = 1'b0;
        m_inst     = 32'h0;
        m_pc       = 32'h0;
        m_trap     = 1'b0;
    endtask

    task automatic step(input bit r, input bit s, input bit bf, input logic [31:0] ba,
                        input bit rdy, input logic [31:0] d);
        bit          e_req;
        bit          taken;
        bit          got;
        bit          mis;
        logic [31:0] tgt;
        @(negedge clk);
        rst = r; stall = s; branchFlag = bf; branchAddr = ba; imemReady = rdy; imemData = d;
        #1;
        cyc++;
        e_req = !r && (m_wrong || !m_valid || !s);
        chk("imemReq", 32'(imemReq), 32'(e_req));
        if (e_req) chk("imemAddr", imemAddr, m_fetch);
        chk("flushIFID", 32'(flushIFID), 32'(!r && bf && !s));
        chk("instValid", 32'(instValid), 32'(m_valid));
        chk("instOut", instOut, m_inst);
        chk("pcOut", pcOut, m_pc);
        chk("misalignTrap", 32'(misalignTrap), 32'(m_trap));

`ifdef PC_MISALIGN_TRAP_EN
        mis = (ba[1:0] != 2'b00);
        tgt = mis ? 32'h0000_0100 : ba;
`else
        mis = 1'b0;
        tgt = {ba[31:2], 2'b00};
`endif
        taken = bf && !s;
        got   = e_req && rdy;
        if (got) $display("cyc %0d fetch addr=%h data=%h %s", cyc, m_fetch, d,
                          (m_wrong || taken) ? "dropped" : "kept");
        if (r) begin
            model_reset();
        end else begin
            if (taken) begin
                m_valid = 1'b0;
                if (mis) m_trap = 1'b1;
            end
            if (m_wrong) begin
                if (got) begin
                    m_wrong = 1'b0;
                    m_fetch = taken ? tgt : m_redirect;
                end else if (taken) begin
                    m_redirect = tgt;
                end
            end else if (taken) begin
                if (got || !e_req) m_fetch = tgt;
                else begin m_wrong = 1'b1; m_redirect = tgt; end
            end else if (got) begin
                m_inst  = d;
                m_pc    = m_fetch;
                m_valid = 1'b1;
                m_fetch = m_fetch + 32'd4;
            end else if (!s) begin
                m_valid = 1'b0;
            end
        end
    endtask

    logic [31:0] a0, a1, a2, j;

    initial begin
        rst = 1'b1; stall = 1'b0; branchFlag = 1'b0; branchAddr = 32'h0;
        imemReady = 1'b0; imemData = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);

        // Reset state and outputs while rst is held.
        step(1, 0, 1, 32'h40, 1, 32'h0);
        chk("rst_req", 32'(imemReq), 32'h0);
        chk("rst_flush", 32'(flushIFID), 32'h0);
        chk("rst_valid", 32'(instValid), 32'h0);
        chk("rst_pcOut", pcOut, 32'h0);
        chk("rst_instOut", instOut, 32'h0);

        // Sequential fetch at one per cycle.
        a0 = $urandom; a1 = $urandom; a2 = $urandom; j = $urandom;
        step(0, 0, 0, 0, 1, a0);      chk("seq_addr0", imemAddr, 32'h0);
        step(0, 0, 0, 0, 1, a1);      chk("seq_addr4", imemAddr, 32'h4); chk("seq_pc0", pcOut, 32'h0);
                                      chk("seq_inst0", instOut, a0);
        step(0, 0, 0, 0, 1, a2);      chk("seq_addr8", imemAddr, 32'h8); chk("seq_pc4", pcOut, 32'h4);
        // Stall holds the output register and blocks new requests.
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0, 1, $urandom);
            chk("stall_req", 32'(imemReq), 32'h0);
            chk("stall_pc", pcOut, 32'h8);
            chk("stall_inst", instOut, a2);
        end
        // Branch during an outstanding fetch: address held, wrong-path data dropped.
        step(0, 0, 1, 32'h40, 0, j);  chk("kill_flush", 32'(flushIFID), 32'h1); chk("kill_addr", imemAddr, 32'hC);
        step(0, 0, 0, 0, 0, j);       chk("kill_hold1", imemAddr, 32'hC); chk("kill_req", 32'(imemReq), 32'h1);
        step(0, 0, 0, 0, 0, j);       chk("kill_hold2", imemAddr, 32'hC);
        step(0, 0, 0, 0, 1, j);       chk("kill_hold3", imemAddr, 32'hC);
        step(0, 0, 0, 0, 1, a0);      chk("redir_40", imemAddr, 32'h40); chk("kill_dropped", 32'(instValid), 32'h0);
        // Branch coinciding with a returned instruction.
        step(0, 0, 1, 32'h80, 1, j);  chk("br_pc40", pcOut, 32'h40);
        step(0, 0, 0, 0, 0, j);       chk("br_nvalid", 32'(instValid), 32'h0); chk("redir_80", imemAddr, 32'h80);
        // Branch under stall is ignored.
        step(0, 1, 1, 32'h200, 0, j); chk("stall_br_flush", 32'(flushIFID), 32'h0);
        step(0, 0, 0, 0, 1, a1);      chk("stall_br_addr", imemAddr, 32'h80);
        step(0, 0, 0, 0, 1, a2);      chk("stall_br_seq", imemAddr, 32'h84);
        // Misaligned branch target.
        step(0, 0, 1, 32'h42, 1, j);
        step(0, 0, 0, 0, 1, a0);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis_addr", imemAddr, 32'h100); chk("mis_trap", 32'(misalignTrap), 32'h1);
`else
        chk("mis_addr", imemAddr, 32'h40);  chk("mis_trap", 32'(misalignTrap), 32'h0);
`endif
        // PC wrap at the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFFC, 1, j);
        step(0, 0, 0, 0, 1, a1);      chk("wrap_top", imemAddr, 32'hFFFF_FFFC);
        step(0, 0, 0, 0, 1, a2);      chk("wrap_zero", imemAddr, 32'h0); chk("wrap_pc", pcOut, 32'hFFFF_FFFC);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] ba;
            case ($urandom_range(0, 9))
                0:       ba = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1, 2:    ba = ($urandom & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
                default: ba = 32'($urandom_range(0, 1023)) << 2;
            endcase
            step($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 99) < 15, ba, $urandom_range(0, 9) < 6, $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
